// File: rtl/comb_eval_arb.sv
// comb_eval_arb: 4-way round-robin arbiter feeding a one-shot
// evaluator of f & ((a & b & c) | (d & e)) with a saturating true-count.
module comb_eval_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [23:0]      op,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             res_valid,
  output logic             res,
  output logic [1:0]       res_id,
  output logic [CNT_W-1:0] true_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       win_q, win_d;
  logic [5:0]       opnd_q, opnd_d;
  logic             res_q, res_d;
  logic [1:0]       res_id_q, res_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic [5:0] slice;
  logic       eval_r;

  // Search begins one past the last grant and wraps back to it.
  always_comb begin
    win   = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    slice = op[5:0];
    unique case (win)
      2'd0: slice = op[5:0];
      2'd1: slice = op[11:6];
      2'd2: slice = op[17:12];
      2'd3: slice = op[23:18];
      default: slice = op[5:0];
    endcase
  end

  // Operand bit order is {a,b,c,d,e,f} with a at the MSB.
  assign eval_r = opnd_q[0] &
                  ((opnd_q[5] & opnd_q[4] & opnd_q[3]) |
                   (opnd_q[2] & opnd_q[1]));

  always_comb begin
    state_d  = state_q;
    gnt_d    = 4'b0000;
    last_d   = last_q;
    win_d    = win_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    res_id_d = res_id_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = EVAL;
          gnt_d   = 4'b0001 << win;
          last_d  = win;
          win_d   = win;
          opnd_d  = slice;
        end
      end
      EVAL: begin
        state_d  = RESP;
        res_d    = eval_r;
        res_id_d = win_q;
        if (eval_r && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      last_q   <= 2'd3;
      win_q    <= 2'd0;
      opnd_q   <= 6'd0;
      res_q    <= 1'b0;
      res_id_q <= 2'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == RESP);
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign true_cnt  = cnt_q;

endmodule

// File: tb/tb_comb_eval_arb.sv
// tb_comb_eval_arb: directed vectors for comb_eval_arb,
// plus a CNT_W=2 instance for counter saturation.
module tb_comb_eval_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req2;
  logic [23:0] op, op2;
  logic [3:0]  gnt, gnt2;
  logic        busy, busy2;
  logic        res_valid, res_valid2;
  logic        res, res2;
  logic [1:0]  res_id, res_id2;
  logic [7:0]  true_cnt;
  logic [1:0]  true_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comb_eval_arb #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res       (res),
    .res_id    (res_id),
    .true_cnt  (true_cnt)
  );

  comb_eval_arb #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .req       (req2),
    .op        (op2),
    .gnt       (gnt2),
    .busy      (busy2),
    .res_valid (res_valid2),
    .res       (res2),
    .res_id    (res_id2),
    .true_cnt  (true_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a negedge with the DUT in IDLE.
  task automatic txn(input string tag, input logic [3:0] r,
                     input logic [23:0] o, input logic [23:0] o_late,
                     input logic [3:0] eg, input logic er,
                     input logic [1:0] eid, input int ecnt);
    req = r;
    op  = o;
    @(negedge clk);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".vld_eval"}, 32'(res_valid), 32'd0);
    req = 4'b0000;
    op  = o_late;
    @(negedge clk);
    check({tag, ".vld"}, 32'(res_valid), 32'd1);
    check({tag, ".res"}, 32'(res), 32'(er));
    check({tag, ".id"}, 32'(res_id), 32'(eid));
    check({tag, ".cnt"}, 32'(true_cnt), 32'(ecnt));
    check({tag, ".gnt_resp"}, 32'(gnt), 32'd0);
    @(negedge clk);
    check({tag, ".vld_idle"}, 32'(res_valid), 32'd0);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    check({tag, ".res_hold"}, 32'(res), 32'(er));
    check({tag, ".id_hold"}, 32'(res_id), 32'(eid));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    op   = 24'd0;
    req2 = 4'b0000;
    op2  = 24'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.vld", 32'(res_valid), 32'd0);
    check("rst.res", 32'(res), 32'd0);
    check("rst.id", 32'(res_id), 32'd0);
    check("rst.cnt", 32'(true_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.busy", 32'(busy), 32'd0);

    txn("single", 4'b0001, {18'd0, 6'b111001}, {18'd0, 6'b111001},
        4'b0001, 1'b1, 2'd0, 1);
    txn("orterm", 4'b0100, {6'd0, 6'b000111, 12'd0},
        {6'd0, 6'b000111, 12'd0}, 4'b0100, 1'b1, 2'd2, 2);
    txn("fzero", 4'b0100, {6'd0, 6'b111110, 12'd0},
        {6'd0, 6'b111110, 12'd0}, 4'b0100, 1'b0, 2'd2, 2);
    txn("lateop", 4'b0010, {12'd0, 6'b111001, 6'd0}, 24'd0,
        4'b0010, 1'b1, 2'd1, 3);

    do_reset();
    req = 4'b1111;
    op  = 24'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("cont%0d.gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
      @(negedge clk);
      check($sformatf("cont%0d.vld", k), 32'(res_valid), 32'd1);
      check($sformatf("cont%0d.id", k), 32'(res_id), 32'(k % 4));
      check($sformatf("cont%0d.gnt_resp", k), 32'(gnt), 32'd0);
      @(negedge clk);
      check($sformatf("cont%0d.gnt_idle", k), 32'(gnt), 32'd0);
    end
    req = 4'b0000;
    @(negedge clk);
    check("cont.cnt", 32'(true_cnt), 32'd0);

    req = 4'b0001;
    op  = {18'd0, 6'b111001};
    @(negedge clk);
    check("midrst.gnt", 32'(gnt), 32'b0001);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check("midrst.vld", 32'(res_valid), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.gnt0", 32'(gnt), 32'd0);
    check("midrst.cnt", 32'(true_cnt), 32'd0);
    rst = 1'b0;
    txn("postrst", 4'b1000, {6'b000111, 18'd0}, {6'b000111, 18'd0},
        4'b1000, 1'b1, 2'd3, 1);

    for (int k = 0; k < 5; k++) begin
      req2 = 4'b0001;
      op2  = {18'd0, 6'b111001};
      @(negedge clk);
      req2 = 4'b0000;
      @(negedge clk);
      check($sformatf("sat%0d.vld", k), 32'(res_valid2), 32'd1);
      check($sformatf("sat%0d.cnt", k), 32'(true_cnt2),
            32'((k < 3) ? k + 1 : 3));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comb_eval_arb.md
COMB_EVAL_ARB -- requirements
Module: comb_eval_arb

Interface
REQ-001 Parameter CNT_W, default 8, width of the true-result counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 op  input  24  operands; op[6i+5:6i] belongs to requester i, bit order {a,b,c,d,e,f} with a at the MSB.
REQ-006 gnt  output  4  one-hot grant, high for exactly one cycle per accepted request.
REQ-007 busy  output  1  high whenever the FSM is not in IDLE.
REQ-008 res_valid  output  1  result strobe, one cycle wide.
REQ-009 res  output  1  evaluated result, f & ((a & b & c) | (d & e)).
REQ-010 res_id  output  2  index of the requester that owns res.
REQ-011 true_cnt  output  CNT_W  count of results equal to 1.

Function
REQ-012 The block SHALL implement a 3-state FSM with states IDLE, EVAL and RESP.
REQ-013 IDLE with req != 0 SHALL move to EVAL on the next edge; with req == 0 it SHALL stay in IDLE.
REQ-014 On the IDLE->EVAL edge the block SHALL:
- register the winner's index,
- latch the winner's 6-bit op slice,
- set gnt to the winner's one-hot code.
REQ-015 EVAL SHALL last one cycle, with gnt high, and move to RESP.
REQ-016 On the EVAL->RESP edge the block SHALL register res from the latched operand and set res_id to the winner's index.
REQ-017 RESP SHALL last one cycle, with res_valid = 1, and move to IDLE unconditionally.
REQ-018 Latency: a request sampled in IDLE at edge t SHALL give gnt during cycle t+1 and res_valid during cycle t+2.
REQ-019 The block SHALL accept at most one request per 3 cycles.
REQ-020 Arbitration SHALL be round-robin:
- the search starts at (last_gnt + 1) mod 4 and ascends with wrap-around,
- last_gnt updates only on a grant.
REQ-021 When several req bits are high in the same cycle, only the round-robin winner SHALL be granted; the others stay pending.
REQ-022 Requesters hold req until they see gnt; req is sampled only in IDLE, and req changes during EVAL or RESP SHALL have no effect.
REQ-023 op is sampled only on the IDLE->EVAL edge; later op changes SHALL NOT affect the in-flight res.
REQ-024 true_cnt SHALL increment on the EVAL->RESP edge when the computed result is 1.
REQ-025 true_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 res and res_id SHALL hold their last values until the next evaluation; only res_valid qualifies them.
REQ-027 gnt SHALL be 0 outside EVAL.
REQ-028 res_valid SHALL be 0 outside RESP.

Reset
REQ-029 While rst = 1 the block SHALL load:
- state = IDLE,
- gnt = 0, busy = 0, res_valid = 0, res = 0, res_id = 0, true_cnt = 0,
- last_gnt = 3, so requester 0 wins the first contention.
REQ-030 rst asserted in EVAL or RESP SHALL abort the in-flight operation: no res_valid is produced for it and true_cnt is unchanged by it.
REQ-031 rst SHALL have priority over every other event in the same cycle.
REQ-032 The first request after rst is released SHALL be accepted on the first edge with rst = 0 and req != 0.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Single request: req = 0001, op slice 0 = 6'b111001 -> gnt = 0001 one cycle later, res_valid with res = 1, res_id = 0 two cycles later, true_cnt = 1.
- OR-term path: req = 0100, op slice 2 = 6'b000111 -> res = 1, res_id = 2; op slice 2 = 6'b111110 (f = 0) -> res = 0 and true_cnt unchanged.
- Contention: req = 1111 held throughout -> gnt order 0001, 0010, 0100, 1000, 0001 at a 3-cycle spacing.
- Late op change: op changed during EVAL -> res reflects the op latched at grant.
- Mid-operation reset: rst pulsed during EVAL -> no res_valid, busy = 0 and gnt = 0 on the next cycle, true_cnt = 0; after release, req = 1000 -> requester 3 is granted.
- Saturation: with CNT_W = 2, five true results in a row -> true_cnt reads 1, 2, 3, 3, 3.
